// File: rtl/banked_regfile_pkg.sv
// Shared types and defaults for the banked register file: controller state
// encoding and bank-index width helper.
package banked_regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREG   = 8;

  typedef enum logic [0:0] {
    RF_RUN   = 1'b0,
    RF_DRAIN = 1'b1
  } rf_state_e;

  // A single bank still needs a one-bit index so the bank port has a width.
  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/banked_regfile_scoreboard.sv
// Pending-write scoreboard for one register bank: one bit per register,
// set on issue, cleared on write-back, wiped wholesale on clear.
module banked_regfile_scoreboard
  import banked_regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            clr_all,
  output logic [NREG-1:0] pending,
  output logic            any_pending
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Set is applied after clear so a same-address issue keeps the newer producer pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_all) begin
      pending_d = '0;
    end else begin
      if (clr_en) pending_d[clr_addr] = 1'b0;
      if (set_en) pending_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending     = pending_q;
  assign any_pending = |pending_q;

endmodule

// File: rtl/banked_regfile.sv
// Multi-port register file with write-back bypass, hazard scoreboard and
// shadow banks switched through a drain-then-acknowledge handshake.
module banked_regfile
  import banked_regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREG    = DEF_NREG,
  parameter int NRD     = 2,
  parameter int BANKS   = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREG),
  localparam int BW     = bank_w(BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_we,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  wb_we,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  reg_clear,
  input  logic                  ctx_req,
  input  logic                  ctx_dir,
  output logic                  ctx_ack,
  output logic                  ctx_err,
  output logic                  iss_stall,
  output logic [BW-1:0]         bank
);

  localparam logic [BW-1:0] BANK_MAX = BW'(BANKS - 1);
  localparam logic          R0_HARD  = (ZERO_R0 != 0);

  rf_state_e         state_q, state_d;
  logic [BW-1:0]     bank_q, bank_d;
  logic [DATA_W-1:0] rf_q [BANKS][NREG];
  logic [DATA_W-1:0] rf_d [BANKS][NREG];
  logic [NREG-1:0]   pending;
  logic              any_pending;
  logic              wr_ok;
  logic              iss_ok;
  logic              at_limit;

  assign wr_ok     = wb_we && !(R0_HARD && (wb_addr == '0));
  assign iss_ok    = iss_we && (state_q == RF_RUN) && !(R0_HARD && (iss_addr == '0));
  assign iss_stall = (state_q == RF_DRAIN);
  assign bank      = bank_q;

  // Register storage: only the active bank is ever written or cleared.
  always_comb begin
    rf_d = rf_q;
    if (reg_clear) begin
      for (int r = 0; r < NREG; r++) rf_d[bank_q][r] = '0;
    end else if (wr_ok) begin
      rf_d[bank_q][wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int r = 0; r < NREG; r++) rf_q[b][r] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  banked_regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (iss_ok),
    .set_addr    (iss_addr),
    .clr_en      (wb_we),
    .clr_addr    (wb_addr),
    .clr_all     (reg_clear),
    .pending     (pending),
    .any_pending (any_pending)
  );

  // Ack waits for an empty scoreboard and no write-back in flight, so the
  // bank never changes under a completing write.
  assign at_limit = ctx_dir ? (bank_q == BANK_MAX) : (bank_q == '0);

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ctx_ack = 1'b0;
    ctx_err = 1'b0;
    case (state_q)
      RF_RUN: begin
        if (ctx_req) state_d = RF_DRAIN;
      end
      RF_DRAIN: begin
        if (!any_pending && !wb_we) begin
          ctx_ack = 1'b1;
          state_d = RF_RUN;
          if (at_limit)     ctx_err = 1'b1;
          else if (ctx_dir) bank_d  = bank_q + 1'b1;
          else              bank_d  = bank_q - 1'b1;
        end
      end
      default: state_d = RF_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_RUN;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          wb_hit;

    assign addr    = rd_addr[gi*AW +: AW];
    assign is_zero = R0_HARD && (addr == '0);
    assign wb_hit  = wb_we && (wb_addr == addr);

    assign rd_data[gi*DATA_W +: DATA_W] = is_zero ? '0 :
                                          wb_hit  ? wb_data :
                                                    rf_q[bank_q][addr];
    assign rd_busy[gi] = !is_zero && pending[addr] && !wb_hit;
  end

endmodule

// File: tb/tb_banked_regfile.sv
// Bench for banked_regfile: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an architectural model.
module tb_banked_regfile;

  localparam int DW    = 16;
  localparam int NREG  = 8;
  localparam int AW    = 3;
  localparam int NRD   = 2;
  localparam int BANKS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              iss_we;
  logic [AW-1:0]     iss_addr;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              reg_clear;
  logic              ctx_req;
  logic              ctx_dir;
  logic              ctx_ack;
  logic              ctx_err;
  logic              iss_stall;
  logic [0:0]        bank;

  int tests = 0;
  int fails = 0;

  // Architectural model: register contents per bank, pending set, active bank,
  // and whether a context switch is being drained.
  bit [DW-1:0]   m_rf [BANKS][NREG];
  bit [NREG-1:0] m_pend;
  int            m_bank;
  bit            m_drain;
  bit            m_ack;
  bit            m_err;

  banked_regfile #(
    .DATA_W (DW), .NREG (NREG), .NRD (NRD), .BANKS (BANKS), .ZERO_R0 (1)
  ) dut (
    .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
    .iss_we (iss_we), .iss_addr (iss_addr), .wb_we (wb_we), .wb_addr (wb_addr),
    .wb_data (wb_data), .reg_clear (reg_clear), .ctx_req (ctx_req), .ctx_dir (ctx_dir),
    .ctx_ack (ctx_ack), .ctx_err (ctx_err), .iss_stall (iss_stall), .bank (bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ack();
    return m_drain && (m_pend == '0) && !wb_we;
  endfunction

  function automatic bit exp_err();
    return exp_ack() && (ctx_dir ? (m_bank == BANKS - 1) : (m_bank == 0));
  endfunction

  task automatic compare_outputs();
    for (int k = 0; k < NRD; k++) begin
      int          a;
      bit          hit;
      logic [31:0] ed;
      a   = int'(rd_addr[k*AW +: AW]);
      hit = wb_we && (int'(wb_addr) == a);
      if (a == 0)   ed = 0;
      else if (hit) ed = 32'(wb_data);
      else          ed = 32'(m_rf[m_bank][a]);
      check($sformatf("rd_data%0d", k), 32'(rd_data[k*DW +: DW]), ed);
      check($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'((a != 0) && m_pend[a] && !hit));
    end
    check("ctx_ack", 32'(ctx_ack), 32'(exp_ack()));
    check("ctx_err", 32'(ctx_err), 32'(exp_err()));
    check("iss_stall", 32'(iss_stall), 32'(m_drain));
    check("bank", 32'(bank), 32'(m_bank));
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int b = 0; b < BANKS; b++)
          for (int r = 0; r < NREG; r++) m_rf[b][r] = '0;
        m_pend  = '0;
        m_bank  = 0;
        m_drain = 1'b0;
      end else begin
        m_ack = exp_ack();
        m_err = exp_err();
        if (reg_clear) begin
          for (int r = 0; r < NREG; r++) m_rf[m_bank][r] = '0;
          m_pend = '0;
        end else begin
          if (wb_we && wb_addr != 0) m_rf[m_bank][wb_addr] = wb_data;
          if (wb_we) m_pend[wb_addr] = 1'b0;
          if (iss_we && !m_drain && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
        if (!m_drain) begin
          m_drain = ctx_req;
        end else if (m_ack) begin
          m_drain = 1'b0;
          if (!m_err) m_bank = ctx_dir ? m_bank + 1 : m_bank - 1;
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compare_outputs();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we     = 1'b0;
    iss_we    = 1'b0;
    reg_clear = 1'b0;
  endtask

  task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = d;
    step();
    idle();
  endtask

  // Request a switch, wait (bounded) for the ack, then drop the request.
  task automatic ctx_do(input bit dir, input bit want_err, input string name);
    int n;
    n = 0;
    idle();
    ctx_req = 1'b1;
    ctx_dir = dir;
    step();
    #2;
    while (!ctx_ack && n < 40) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({name, "_ack"}, 32'(ctx_ack), 32'd1);
    check({name, "_err"}, 32'(ctx_err), 32'(want_err));
    step();
    ctx_req = 1'b0;
  endtask

  initial begin
    bit ack_seen;
    rst = 1'b1;
    rd_addr = '0; iss_we = 1'b0; iss_addr = '0; wb_we = 1'b0; wb_addr = '0;
    wb_data = '0; reg_clear = 1'b0; ctx_req = 1'b0; ctx_dir = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset clears data and pending state.
    idle();
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
    iss_we = 1'b1; iss_addr = 3'd3;
    step();
    idle();
    rd_addr = {3'd0, 3'd3};
    #2;
    check("pre_reset_r3", 32'(rd_data[15:0]), 32'h1234);
    check("pre_reset_busy", 32'(rd_busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("reset_r3", 32'(rd_data[15:0]), 32'h0);
    check("reset_busy", 32'(rd_busy[0]), 32'd0);
    check("reset_bank", 32'(bank), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step();

    // Bypass and hardwired R0.
    wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF; rd_addr = {3'd0, 3'd5};
    #2;
    check("bypass_data", 32'(rd_data[15:0]), 32'hBEEF);
    check("bypass_busy", 32'(rd_busy[0]), 32'd0);
    step();
    wb_addr = 3'd0; wb_data = 16'hFFFF; rd_addr = {3'd5, 3'd0};
    #2;
    check("r0_bypass", 32'(rd_data[15:0]), 32'h0);
    step();
    idle();
    #2;
    check("r0_read", 32'(rd_data[15:0]), 32'h0);
    check("r5_read", 32'(rd_data[31:16]), 32'hBEEF);

    // Scoreboard set/clear ordering.
    iss_we = 1'b1; iss_addr = 3'd2;
    step();
    idle();
    rd_addr = {3'd0, 3'd2};
    #2;
    check("sb_busy", 32'(rd_busy[0]), 32'd1);
    wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'h0202; iss_we = 1'b1; iss_addr = 3'd2;
    step();
    idle();
    #2;
    check("sb_set_wins", 32'(rd_busy[0]), 32'd1);
    do_wb(3'd2, 16'h0203);
    #2;
    check("sb_cleared", 32'(rd_busy[0]), 32'd0);

    // Context enter waits for the outstanding write-back.
    do_wb(3'd1, 16'h0011);
    iss_we = 1'b1; iss_addr = 3'd4;
    step();
    idle();
    ctx_req = 1'b1; ctx_dir = 1'b1;
    step();
    #2;
    check("drain_stall", 32'(iss_stall), 32'd1);
    check("drain_no_ack", 32'(ctx_ack), 32'd0);
    step();
    wb_we = 1'b1; wb_addr = 3'd4; wb_data = 16'h0044;
    #2;
    check("ack_gated_by_wb", 32'(ctx_ack), 32'd0);
    step();
    idle();
    #2;
    check("enter_ack", 32'(ctx_ack), 32'd1);
    check("enter_err", 32'(ctx_err), 32'd0);
    step();
    ctx_req = 1'b0;
    rd_addr = {3'd0, 3'd1};
    #2;
    check("enter_bank", 32'(bank), 32'd1);
    check("bank1_r1", 32'(rd_data[15:0]), 32'h0);
    check("enter_unstall", 32'(iss_stall), 32'd0);
    do_wb(3'd1, 16'h0022);
    #2;
    check("bank1_r1_wr", 32'(rd_data[15:0]), 32'h0022);
    ctx_do(1'b0, 1'b0, "return");
    #2;
    check("return_bank", 32'(bank), 32'd0);
    check("bank0_r1", 32'(rd_data[15:0]), 32'h0011);

    // Overflow / underflow.
    ctx_do(1'b0, 1'b1, "underflow");
    #2;
    check("underflow_bank", 32'(bank), 32'd0);
    ctx_do(1'b1, 1'b0, "enter2");
    ctx_do(1'b1, 1'b1, "overflow");
    #2;
    check("overflow_bank", 32'(bank), 32'd1);

    // reg_clear in bank1 beats a same-cycle write-back and issue.
    do_wb(3'd3, 16'h3333);
    iss_we = 1'b1; iss_addr = 3'd6;
    step();
    idle();
    reg_clear = 1'b1; wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h7777;
    iss_we = 1'b1; iss_addr = 3'd5;
    step();
    idle();
    rd_addr = {3'd6, 3'd3};
    #2;
    check("clear_r3", 32'(rd_data[15:0]), 32'h0);
    check("clear_busy_r6", 32'(rd_busy[1]), 32'd0);
    ctx_do(1'b0, 1'b0, "clear_return");
    rd_addr = {3'd5, 3'd1};
    #2;
    check("intact_r1", 32'(rd_data[15:0]), 32'h0011);
    check("intact_r5", 32'(rd_data[31:16]), 32'hBEEF);

    // Randomized traffic, including a reset in the middle.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      ack_seen = ctx_ack;
      @(posedge clk);
      #1;
      wb_we     = ($urandom_range(0, 1) == 1);
      wb_addr   = AW'($urandom);
      wb_data   = DW'($urandom);
      iss_we    = ($urandom_range(0, 2) == 0);
      iss_addr  = AW'($urandom);
      reg_clear = ($urandom_range(0, 39) == 0);
      rd_addr   = (NRD*AW)'($urandom);
      if (ack_seen) begin
        ctx_req = 1'b0;
      end else if (!ctx_req && $urandom_range(0, 11) == 0) begin
        ctx_req = 1'b1;
        ctx_dir = ($urandom_range(0, 1) == 1);
      end
      if (i == 450) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end

    idle();
    ctx_req = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
